// File: rtl/bram_axis_packetizer_if.sv
// AXI-Stream link carrying the packetizer's framed output.
interface bram_axis_packetizer_if #(
  parameter int DW = 16
);
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;
  logic          tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/bram_axis_packetizer.sv
// Reads a bank x address rectangle from the banked BRAM read port and emits
// it as a framed AXI-Stream packet: 4 header words, then bank-major data.
module bram_axis_packetizer #(
  parameter int            DW         = 16,
  parameter int            NUM_BRAMS  = 16,
  parameter int            ADDR_WIDTH = 10,
  parameter int            BANK_W     = 4,
  parameter logic [DW-1:0] MAGIC      = 16'hC0DE,
  parameter int            FIFO_DEPTH = 4
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     start,
  input  logic [BANK_W-1:0]        cfg_bank_first,
  input  logic [BANK_W-1:0]        cfg_bank_last,
  input  logic [ADDR_WIDTH-1:0]    cfg_addr_start,
  input  logic [ADDR_WIDTH:0]      cfg_addr_count,
  output logic                     rd_en,
  output logic [BANK_W-1:0]        rd_bank,
  output logic [ADDR_WIDTH-1:0]    rd_addr,
  input  logic [NUM_BRAMS*DW-1:0]  rd_data_flat,
  bram_axis_packetizer_if.master   m_axis,
  output logic                     busy,
  output logic                     done,
  output logic                     err_cfg
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_WIDTH+1:0] ADDR_SPAN = (ADDR_WIDTH+2)'(1) << ADDR_WIDTH;

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_DRAIN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [BANK_W-1:0]     first_q, first_d, last_q, last_d, bank_q, bank_d;
  logic [BANK_W-1:0]     ret_bank_q, ret_bank_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d, addr_q, addr_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d, off_q, off_d;
  logic [1:0]            hdr_q, hdr_d;
  logic                  ret_vld_q, ret_vld_d, ret_last_q, ret_last_d;
  logic                  err_q, err_d;
  logic [CW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

  // Entry = {last flag, data word}
  logic [DW:0]           mem_q [FIFO_DEPTH];
  logic [DW:0]           head, push_word;
  logic                  push, pop;
  logic [CW-1:0]         fifo_cnt;
  logic                  fifo_full, fifo_empty;
  logic [CW:0]           credit;
  logic                  credit_ok, hdr_push, rd_go, off_wrap, rd_final, cfg_ok;
  logic [ADDR_WIDTH+1:0] cfg_span;

  assign fifo_cnt   = wr_ptr_q - rd_ptr_q;
  assign fifo_full  = (fifo_cnt == CW'(FIFO_DEPTH));
  assign fifo_empty = (fifo_cnt == '0);
  assign pop        = !fifo_empty && m_axis.tready;
  assign head       = mem_q[rd_ptr_q[PW-1:0]];

  assign m_axis.tvalid = !fifo_empty;
  assign m_axis.tdata  = fifo_empty ? '0 : head[DW-1:0];
  assign m_axis.tlast  = !fifo_empty && head[DW];

  assign cfg_span = {2'b00, cfg_addr_start} + {1'b0, cfg_addr_count};
  assign cfg_ok   = (cfg_bank_first <= cfg_bank_last) && (cfg_span <= ADDR_SPAN);

  // Credit counts entries already stored, the read in flight and a header
  // word being pushed this cycle, so a read issued now always has a slot.
  assign hdr_push  = (state_q == S_HDR) && !fifo_full;
  assign credit    = {1'b0, fifo_cnt} + {{CW{1'b0}}, ret_vld_q} + {{CW{1'b0}}, hdr_push};
  assign credit_ok = credit < (CW+1)'(FIFO_DEPTH);
  // The first read overlaps the W3 push so data follows the header bubble-free.
  assign rd_go     = credit_ok && ((state_q == S_DATA) ||
                                   (hdr_push && hdr_q == 2'd3 && cnt_q != '0));
  assign off_wrap  = (off_q == cnt_q - (ADDR_WIDTH+1)'(1));
  assign rd_final  = off_wrap && (bank_q == last_q);

  assign rd_bank = bank_q;
  assign rd_addr = addr_q;
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign err_cfg = err_q;

  // FIFO write source: returning read data, otherwise the current header word
  always_comb begin
    push      = 1'b0;
    push_word = '0;
    if (ret_vld_q) begin
      push      = 1'b1;
      push_word = {ret_last_q, rd_data_flat[ret_bank_q*DW +: DW]};
    end else if (hdr_push) begin
      push = 1'b1;
      unique case (hdr_q)
        2'd0:    push_word = {1'b0, MAGIC};
        2'd1:    push_word = {1'b0, DW'({last_q, first_q})};
        2'd2:    push_word = {1'b0, DW'(base_q)};
        default: push_word = {(cnt_q == '0), DW'(cnt_q)};
      endcase
    end
    wr_ptr_d = wr_ptr_q + CW'(push);
    rd_ptr_d = rd_ptr_q + CW'(pop);
  end

  // Next-state, read issue and address walk
  always_comb begin
    state_d    = state_q;
    first_d    = first_q;
    last_d     = last_q;
    base_d     = base_q;
    cnt_d      = cnt_q;
    bank_d     = bank_q;
    addr_d     = addr_q;
    off_d      = off_q;
    hdr_d      = hdr_q;
    ret_vld_d  = 1'b0;
    ret_last_d = 1'b0;
    ret_bank_d = ret_bank_q;
    err_d      = 1'b0;
    rd_en      = 1'b0;

    if (rd_go) begin
      rd_en      = 1'b1;
      ret_vld_d  = 1'b1;
      ret_last_d = rd_final;
      ret_bank_d = bank_q;
      if (off_wrap) begin
        off_d  = '0;
        addr_d = base_q;
        bank_d = bank_q + BANK_W'(1);
      end else begin
        off_d  = off_q + (ADDR_WIDTH+1)'(1);
        addr_d = addr_q + ADDR_WIDTH'(1);
      end
    end

    unique case (state_q)
      S_IDLE: if (start) begin
        if (cfg_ok) begin
          first_d = cfg_bank_first;
          last_d  = cfg_bank_last;
          base_d  = cfg_addr_start;
          cnt_d   = cfg_addr_count;
          bank_d  = cfg_bank_first;
          addr_d  = cfg_addr_start;
          off_d   = '0;
          hdr_d   = 2'd0;
          state_d = S_HDR;
        end else begin
          err_d = 1'b1;
        end
      end
      S_HDR: if (hdr_push) begin
        hdr_d = hdr_q + 2'd1;
        if (hdr_q == 2'd3) begin
          if (cnt_q == '0 || (rd_go && rd_final)) state_d = S_DRAIN;
          else                                    state_d = S_DATA;
        end
      end
      S_DATA:  if (rd_go && rd_final) state_d = S_DRAIN;
      S_DRAIN: if (pop && head[DW]) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= S_IDLE;
      first_q    <= '0;
      last_q     <= '0;
      base_q     <= '0;
      cnt_q      <= '0;
      bank_q     <= '0;
      addr_q     <= '0;
      off_q      <= '0;
      hdr_q      <= '0;
      ret_vld_q  <= 1'b0;
      ret_last_q <= 1'b0;
      ret_bank_q <= '0;
      err_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      first_q    <= first_d;
      last_q     <= last_d;
      base_q     <= base_d;
      cnt_q      <= cnt_d;
      bank_q     <= bank_d;
      addr_q     <= addr_d;
      off_q      <= off_d;
      hdr_q      <= hdr_d;
      ret_vld_q  <= ret_vld_d;
      ret_last_q <= ret_last_d;
      ret_bank_q <= ret_bank_d;
      err_q      <= err_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // FIFO storage; contents are don't-care while the pointers say empty
  always_ff @(posedge aclk) begin
    if (push) mem_q[wr_ptr_q[PW-1:0]] <= push_word;
  end
endmodule

// File: tb/tb_bram_axis_packetizer.sv
// Randomized self-checking bench for bram_axis_packetizer.
module tb_bram_axis_packetizer;
  localparam int DW = 16, NB = 16, AW = 10, BW = 4;

  logic            aclk = 1'b0;
  logic            aresetn = 1'b0;
  logic            start = 1'b0;
  logic [BW-1:0]   cfg_bank_first = '0, cfg_bank_last = '0;
  logic [AW-1:0]   cfg_addr_start = '0;
  logic [AW:0]     cfg_addr_count = '0;
  logic            rd_en;
  logic [BW-1:0]   rd_bank;
  logic [AW-1:0]   rd_addr;
  logic [NB*DW-1:0] rd_data_flat = '0;
  logic            busy, done, err_cfg;

  bram_axis_packetizer_if #(.DW(DW)) axis_if ();

  bram_axis_packetizer #(.DW(DW), .NUM_BRAMS(NB), .ADDR_WIDTH(AW), .BANK_W(BW),
                         .MAGIC(16'hC0DE), .FIFO_DEPTH(4)) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start),
    .cfg_bank_first(cfg_bank_first), .cfg_bank_last(cfg_bank_last),
    .cfg_addr_start(cfg_addr_start), .cfg_addr_count(cfg_addr_count),
    .rd_en(rd_en), .rd_bank(rd_bank), .rd_addr(rd_addr),
    .rd_data_flat(rd_data_flat), .m_axis(axis_if),
    .busy(busy), .done(done), .err_cfg(err_cfg));

  always #5 aclk = ~aclk;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  // BRAM contents: word at bank b, address a is {b, 2'b00, a}
  function automatic logic [15:0] bram_word(int b, int a);
    logic [3:0]  bb = b[3:0];
    logic [11:0] aa = a[11:0];
    return {bb, aa};
  endfunction

  always @(posedge aclk)
    if (rd_en)
      for (int b = 0; b < NB; b++) rd_data_flat[b*DW +: DW] <= bram_word(b, int'(rd_addr));

  // Reference packet built directly from the framing rules
  logic [15:0] exp_q[$];
  task automatic build_exp(int f, int l, int s, int c);
    exp_q.delete();
    exp_q.push_back(16'hC0DE);
    exp_q.push_back(16'((l << 4) | f));
    exp_q.push_back(16'(s));
    exp_q.push_back(16'(c));
    for (int b = f; b <= l; b++)
      for (int i = 0; i < c; i++) exp_q.push_back(bram_word(b, s + i));
  endtask

  // Observation state, sampled on the falling edge
  logic [15:0] got_data[$];
  logic        got_last[$];
  int          got_cyc[$];
  int first_v, done_cnt, done_cyc, err_cnt, err_cyc, rd_cnt, busy_cnt, stall_viol;
  logic prev_stall, prev_last;
  logic [15:0] prev_data;

  task automatic clear_mon();
    got_data.delete(); got_last.delete(); got_cyc.delete();
    first_v = -1; done_cnt = 0; done_cyc = -1; err_cnt = 0; err_cyc = -1;
    rd_cnt = 0; busy_cnt = 0; stall_viol = 0;
    prev_stall = 1'b0; prev_last = 1'b0; prev_data = '0;
  endtask

  always @(negedge aclk) begin
    if (aresetn) begin
      if (axis_if.tvalid && first_v < 0) first_v = cyc;
      if (prev_stall && (!axis_if.tvalid || axis_if.tdata !== prev_data || axis_if.tlast !== prev_last))
        stall_viol++;
      prev_stall = axis_if.tvalid && !axis_if.tready;
      prev_data  = axis_if.tdata;
      prev_last  = axis_if.tlast;
      if (axis_if.tvalid && axis_if.tready) begin
        got_data.push_back(axis_if.tdata);
        got_last.push_back(axis_if.tlast);
        got_cyc.push_back(cyc);
      end
      if (rd_en) rd_cnt++;
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (err_cfg) begin err_cnt++; err_cyc = cyc; end
    end
  end

  function automatic logic tr_val(int mode, int k);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (k >= 6 && k < 26) ? 1'b0 : ((k % 2) == 0);
    return ($urandom_range(3, 0) != 0);
  endfunction

  task automatic pulse_start(int f, int l, int s, int c, output int sc);
    @(posedge aclk); #1;
    cfg_bank_first = BW'(f); cfg_bank_last = BW'(l);
    cfg_addr_start = AW'(s); cfg_addr_count = (AW+1)'(c);
    start = 1'b1; sc = cyc;
    @(posedge aclk); #1;
    start = 1'b0;
    // scramble cfg: the running packet must use the latched copy
    cfg_bank_first = BW'($urandom); cfg_bank_last = BW'($urandom);
    cfg_addr_start = AW'($urandom); cfg_addr_count = (AW+1)'($urandom);
  endtask

  task automatic wait_done(int mode, int limit, int poke, output bit to);
    int k = 1;
    to = 1'b1;
    while (k < limit) begin
      if (done_cnt > 0) begin to = 1'b0; break; end
      @(posedge aclk); #1; k++;
      axis_if.tready = tr_val(mode, k);
      if (k == poke) begin
        cfg_bank_first = 3; cfg_bank_last = 2; cfg_addr_start = 0; cfg_addr_count = 5;
        start = 1'b1;
      end else start = 1'b0;
    end
    start = 1'b0;
    axis_if.tready = 1'b1;
  endtask

  task automatic test_reset();
    aresetn = 1'b0; axis_if.tready = 1'b0;
    repeat (3) @(posedge aclk); #1;
    n_cmp++;
    if ({rd_en, rd_bank, rd_addr, axis_if.tdata, axis_if.tvalid, axis_if.tlast, busy, done, err_cfg} !== '0) begin
      n_bad++; $display("FAIL reset_outputs got rd_en=%b tvalid=%b busy=%b done=%b err=%b want all 0",
                        rd_en, axis_if.tvalid, busy, done, err_cfg);
    end
    aresetn = 1'b1; axis_if.tready = 1'b1;
    repeat (2) @(posedge aclk); #1;
    n_cmp++;
    if ({rd_en, axis_if.tvalid, busy, done, err_cfg} !== '0) begin
      n_bad++; $display("FAIL idle_after_reset got %b want 00000", {rd_en, axis_if.tvalid, busy, done, err_cfg});
    end
  endtask

  task automatic test_basic();
    int sc; bit to; int n;
    clear_mon(); build_exp(0, 1, 'h10, 3);
    pulse_start(0, 1, 'h10, 3, sc);
    wait_done(0, 200, -1, to);
    n = got_data.size();
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL basic_timeout got timeout want done"); end
    n_cmp++; if (n !== 10) begin n_bad++; $display("FAIL basic_len got %0d want 10", n); end
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      logic el = (i == exp_q.size() - 1);
      n_cmp++;
      if ({got_last[i], got_data[i]} !== {el, exp_q[i]}) begin
        n_bad++; $display("FAIL basic_beat%0d got %h/%b want %h/%b", i, got_data[i], got_last[i], exp_q[i], el);
      end
    end
    n_cmp++; if (first_v !== sc + 2) begin n_bad++; $display("FAIL basic_first_valid got %0d want %0d", first_v - sc, 2); end
    if (n > 0) begin
      n_cmp++; if (done_cyc !== got_cyc[n-1] + 1) begin n_bad++; $display("FAIL basic_done_cycle got %0d want %0d", done_cyc, got_cyc[n-1] + 1); end
      n_cmp++; if (got_cyc[n-1] - got_cyc[0] !== n - 1) begin n_bad++; $display("FAIL basic_bubbles got span %0d want %0d", got_cyc[n-1] - got_cyc[0], n - 1); end
    end
    n_cmp++; if (rd_cnt !== 6) begin n_bad++; $display("FAIL basic_reads got %0d want 6", rd_cnt); end
    n_cmp++; if (done_cnt !== 1 || err_cnt !== 0) begin n_bad++; $display("FAIL basic_pulses got done=%0d err=%0d want 1/0", done_cnt, err_cnt); end
    repeat (2) @(posedge aclk); #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_clear got %b want 0", busy); end
  endtask

  task automatic test_backpressure();
    int sc; bit to; int n;
    clear_mon(); build_exp(0, 1, 'h10, 3);
    axis_if.tready = 1'b0;
    pulse_start(0, 1, 'h10, 3, sc);
    wait_done(1, 400, -1, to);
    n = got_data.size();
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL bp_timeout got timeout want done"); end
    n_cmp++; if (n !== 10) begin n_bad++; $display("FAIL bp_len got %0d want 10", n); end
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      logic el = (i == exp_q.size() - 1);
      n_cmp++;
      if ({got_last[i], got_data[i]} !== {el, exp_q[i]}) begin
        n_bad++; $display("FAIL bp_beat%0d got %h/%b want %h/%b", i, got_data[i], got_last[i], exp_q[i], el);
      end
    end
    n_cmp++; if (stall_viol !== 0) begin n_bad++; $display("FAIL bp_stable got %0d violations want 0", stall_viol); end
    if (n > 0) begin
      n_cmp++; if (done_cyc !== got_cyc[n-1] + 1) begin n_bad++; $display("FAIL bp_done_cycle got %0d want %0d", done_cyc, got_cyc[n-1] + 1); end
    end
  endtask

  task automatic test_header_only();
    int sc; bit to; int n;
    clear_mon(); build_exp(5, 5, 'h10, 0);
    pulse_start(5, 5, 'h10, 0, sc);
    wait_done(0, 100, -1, to);
    n = got_data.size();
    n_cmp++; if (to !== 1'b0 || n !== 4) begin n_bad++; $display("FAIL hdr_len got %0d timeout=%0b want 4", n, to); end
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      logic el = (i == exp_q.size() - 1);
      n_cmp++;
      if ({got_last[i], got_data[i]} !== {el, exp_q[i]}) begin
        n_bad++; $display("FAIL hdr_beat%0d got %h/%b want %h/%b", i, got_data[i], got_last[i], exp_q[i], el);
      end
    end
    n_cmp++; if (rd_cnt !== 0) begin n_bad++; $display("FAIL hdr_no_reads got %0d want 0", rd_cnt); end
  endtask

  task automatic test_rejects();
    int sc; bit to; int n;
    // bank range inverted
    clear_mon();
    pulse_start(3, 2, 0, 1, sc);
    repeat (6) @(posedge aclk); #1;
    n_cmp++; if (err_cnt !== 1 || err_cyc !== sc + 1) begin n_bad++; $display("FAIL rej_bank got err=%0d at +%0d want 1 at +1", err_cnt, err_cyc - sc); end
    n_cmp++; if (first_v !== -1 || busy_cnt !== 0) begin n_bad++; $display("FAIL rej_bank_quiet got tvalid_at=%0d busy=%0d want -1/0", first_v, busy_cnt); end
    // address range past the end of the bank
    clear_mon();
    pulse_start(0, 0, 'h3FF, 2, sc);
    repeat (6) @(posedge aclk); #1;
    n_cmp++; if (err_cnt !== 1 || first_v !== -1 || busy_cnt !== 0) begin
      n_bad++; $display("FAIL rej_addr got err=%0d tvalid_at=%0d busy=%0d want 1/-1/0", err_cnt, first_v, busy_cnt);
    end
    // exactly reaching the end is legal
    clear_mon(); build_exp(2, 2, 'h3FE, 2);
    pulse_start(2, 2, 'h3FE, 2, sc);
    wait_done(0, 100, -1, to);
    n = got_data.size();
    n_cmp++; if (to !== 1'b0 || err_cnt !== 0 || n !== 6) begin n_bad++; $display("FAIL edge_accept got len=%0d err=%0d want 6/0", n, err_cnt); end
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      logic el = (i == exp_q.size() - 1);
      n_cmp++;
      if ({got_last[i], got_data[i]} !== {el, exp_q[i]}) begin
        n_bad++; $display("FAIL edge_beat%0d got %h/%b want %h/%b", i, got_data[i], got_last[i], exp_q[i], el);
      end
    end
    // start while busy is ignored
    clear_mon(); build_exp(0, 1, 'h10, 3);
    pulse_start(0, 1, 'h10, 3, sc);
    wait_done(0, 200, 3, to);
    n = got_data.size();
    n_cmp++; if (to !== 1'b0 || err_cnt !== 0 || done_cnt !== 1 || n !== 10) begin
      n_bad++; $display("FAIL busy_start got len=%0d err=%0d done=%0d want 10/0/1", n, err_cnt, done_cnt);
    end
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_data[i] !== exp_q[i]) begin n_bad++; $display("FAIL busy_beat%0d got %h want %h", i, got_data[i], exp_q[i]); end
    end
    repeat (4) @(posedge aclk); #1;
    n_cmp++; if (busy !== 1'b0 || done_cnt !== 1) begin n_bad++; $display("FAIL busy_no_restart got busy=%b done=%0d want 0/1", busy, done_cnt); end
  endtask

  task automatic test_full_region();
    int sc; bit to; int n; int bad = 0;
    clear_mon(); build_exp(0, 15, 0, 1024);
    pulse_start(0, 15, 0, 1024, sc);
    wait_done(0, 17000, -1, to);
    n = got_data.size();
    n_cmp++; if (to !== 1'b0 || n !== 16388) begin n_bad++; $display("FAIL full_len got %0d timeout=%0b want 16388", n, to); end
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      logic el = (i == exp_q.size() - 1);
      n_cmp++;
      if ({got_last[i], got_data[i]} !== {el, exp_q[i]}) begin
        n_bad++; bad++;
        if (bad <= 8) $display("FAIL full_beat%0d got %h/%b want %h/%b", i, got_data[i], got_last[i], exp_q[i], el);
      end
    end
    if (n > 0) begin
      n_cmp++; if (got_data[n-1] !== bram_word(15, 'h3FF)) begin n_bad++; $display("FAIL full_last_word got %h want %h", got_data[n-1], bram_word(15, 'h3FF)); end
      n_cmp++; if (got_cyc[0] !== sc + 2 || got_cyc[n-1] - got_cyc[0] !== n - 1) begin
        n_bad++; $display("FAIL full_bubbles got first=+%0d span=%0d want +2/%0d", got_cyc[0] - sc, got_cyc[n-1] - got_cyc[0], n - 1);
      end
    end
  endtask

  task automatic test_reset_mid();
    int sc; bit to; int n; int k = 0; int lasts = 0;
    clear_mon();
    pulse_start(0, 1, 'h10, 3, sc);
    while (got_data.size() < 6 && k < 100) begin @(posedge aclk); #1; k++; end
    n_cmp++; if (got_data.size() < 6) begin n_bad++; $display("FAIL mid_reach got %0d beats want 6", got_data.size()); end
    aresetn = 1'b0; #1;
    n_cmp++;
    if ({rd_en, rd_bank, rd_addr, axis_if.tdata, axis_if.tvalid, axis_if.tlast, busy, done, err_cfg} !== '0) begin
      n_bad++; $display("FAIL mid_reset_outputs got tvalid=%b tdata=%h busy=%b want 0", axis_if.tvalid, axis_if.tdata, busy);
    end
    foreach (got_last[i]) if (got_last[i]) lasts++;
    n_cmp++; if (lasts !== 0) begin n_bad++; $display("FAIL mid_no_tlast got %0d want 0", lasts); end
    repeat (2) @(posedge aclk); #1;
    aresetn = 1'b1;
    clear_mon(); build_exp(0, 1, 'h10, 3);
    pulse_start(0, 1, 'h10, 3, sc);
    wait_done(0, 200, -1, to);
    n = got_data.size();
    n_cmp++; if (to !== 1'b0 || n !== 10) begin n_bad++; $display("FAIL mid_after_len got %0d want 10", n); end
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      logic el = (i == exp_q.size() - 1);
      n_cmp++;
      if ({got_last[i], got_data[i]} !== {el, exp_q[i]}) begin
        n_bad++; $display("FAIL mid_beat%0d got %h/%b want %h/%b", i, got_data[i], got_last[i], exp_q[i], el);
      end
    end
  endtask

  task automatic test_random();
    int sc; bit to; int n; int f, l, c, s;
    for (int it = 0; it < 20; it++) begin
      f = $urandom_range(15, 0);
      l = $urandom_range((f + 2 > 15) ? 15 : f + 2, f);
      c = $urandom_range(12, 0);
      s = (it % 5 == 0) ? 1024 - c : $urandom_range(1024 - c, 0);
      if (s > 1023) s = 1023;
      clear_mon(); build_exp(f, l, s, c);
      axis_if.tready = tr_val(2, 0);
      pulse_start(f, l, s, c, sc);
      wait_done(2, 400, -1, to);
      n = got_data.size();
      n_cmp++; if (to !== 1'b0 || n !== exp_q.size()) begin
        n_bad++; $display("FAIL rand%0d_len got %0d want %0d (f=%0d l=%0d s=%0d c=%0d)", it, n, exp_q.size(), f, l, s, c);
      end
      for (int i = 0; i < n && i < exp_q.size(); i++) begin
        logic el = (i == exp_q.size() - 1);
        n_cmp++;
        if ({got_last[i], got_data[i]} !== {el, exp_q[i]}) begin
          n_bad++; $display("FAIL rand%0d_beat%0d got %h/%b want %h/%b", it, i, got_data[i], got_last[i], exp_q[i], el);
        end
      end
      n_cmp++; if (stall_viol !== 0 || err_cnt !== 0 || done_cnt !== 1) begin
        n_bad++; $display("FAIL rand%0d_ctl got stall=%0d err=%0d done=%0d want 0/0/1", it, stall_viol, err_cnt, done_cnt);
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got no finish want finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    axis_if.tready = 1'b0;
    clear_mon();
    test_reset();
    test_basic();
    test_backpressure();
    test_header_only();
    test_rejects();
    test_full_region();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
